// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- RV32I writeback stage.
//
// Takes completed instructions from execute. Non-loads are written straight to
// the register-file port; loads park in WAIT_LOAD until the data-memory
// response arrives, then the word is aligned and sign/zero-extended before the
// write. Misaligned loads and loads with an illegal funct3 raise a one-cycle
// o_load_fault instead of waiting. Every register, including the output
// pulses, only advances on edges where i_clk_en is high, so a pending write
// strobe is seen by the register file exactly once.
//
// Optional feature macro: WB_FWD_EN (adds rs1/rs2 forwarding-hit outputs).
//
// Ports:
//   i_clk, i_rst_n (async active-low), i_clk_en (global clock enable)
//   i_valid / o_ready          : execute handshake (o_ready = state is IDLE)
//   i_rd_addr, i_rd_en         : destination register and its write enable
//   i_result                   : ALU result for non-loads
//   i_is_load, i_funct3,
//   i_addr_lo                  : load size/sign and effective-address low bits
//   i_mem_rvalid, i_mem_rdata  : data-memory response
//   o_rd_addr, o_rd_data,
//   o_rd_write                 : register-file write port (registered)
//   o_load_fault               : registered one-cycle fault pulse
//   o_busy                     : high while waiting for load data
//   [WB_FWD_EN] i_rs1_addr, i_rs2_addr, o_fwd_rs1_hit, o_fwd_rs2_hit
// -----------------------------------------------------------------------------
module wb_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clk_en,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_en,
  input  logic [31:0] i_result,
  input  logic        i_is_load,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_write,
  output logic        o_load_fault,
  output logic        o_busy
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_fwd_rs1_hit,
  output logic        o_fwd_rs2_hit
`endif
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Load is unusable: illegal funct3 or an address not aligned to its size.
  function automatic logic f_load_fault(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic fault;
    case (funct3)
      F3_LB, F3_LBU: fault = 1'b0;
      F3_LH, F3_LHU: fault = addr_lo[0];
      F3_LW:         fault = (addr_lo != 2'b00);
      default:       fault = 1'b1;
    endcase
    return fault;
  endfunction

  // Select the addressed byte/half of the memory word and extend it.
  function automatic logic [31:0] f_align(input logic [2:0]  funct3,
                                          input logic [1:0]  addr_lo,
                                          input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    case (addr_lo)
      2'b00:   byte_v = rdata[7:0];
      2'b01:   byte_v = rdata[15:8];
      2'b10:   byte_v = rdata[23:16];
      2'b11:   byte_v = rdata[31:24];
      default: byte_v = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_v = rdata[31:16];
    end else begin
      half_v = rdata[15:0];
    end
    case (funct3)
      F3_LB:   res = {{24{byte_v[7]}}, byte_v};
      F3_LH:   res = {{16{half_v[15]}}, half_v};
      F3_LW:   res = rdata;
      F3_LBU:  res = {24'h000000, byte_v};
      F3_LHU:  res = {16'h0000, half_v};
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

  logic [0:0]  r_state;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_rd_data;
  logic        r_rd_write;
  logic        r_load_fault;
  logic [4:0]  r_ld_rd_addr;
  logic        r_ld_rd_en;
  logic [2:0]  r_ld_funct3;
  logic [1:0]  r_ld_addr_lo;

  logic [0:0]  w_state_nxt;
  logic [4:0]  w_rd_addr_nxt;
  logic [31:0] w_rd_data_nxt;
  logic        w_rd_write_nxt;
  logic        w_load_fault_nxt;
  logic [4:0]  w_ld_rd_addr_nxt;
  logic        w_ld_rd_en_nxt;
  logic [2:0]  w_ld_funct3_nxt;
  logic [1:0]  w_ld_addr_lo_nxt;

  // Next-state and next-output decode; pulses default low, data holds.
  always_comb begin
    w_state_nxt      = r_state;
    w_rd_addr_nxt    = r_rd_addr;
    w_rd_data_nxt    = r_rd_data;
    w_rd_write_nxt   = 1'b0;
    w_load_fault_nxt = 1'b0;
    w_ld_rd_addr_nxt = r_ld_rd_addr;
    w_ld_rd_en_nxt   = r_ld_rd_en;
    w_ld_funct3_nxt  = r_ld_funct3;
    w_ld_addr_lo_nxt = r_ld_addr_lo;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          if (!i_is_load) begin
            w_rd_addr_nxt  = i_rd_addr;
            w_rd_data_nxt  = i_result;
            w_rd_write_nxt = i_rd_en && (i_rd_addr != 5'd0);
          end else if (f_load_fault(i_funct3, i_addr_lo)) begin
            w_load_fault_nxt = 1'b1;
          end else begin
            w_ld_rd_addr_nxt = i_rd_addr;
            w_ld_rd_en_nxt   = i_rd_en;
            w_ld_funct3_nxt  = i_funct3;
            w_ld_addr_lo_nxt = i_addr_lo;
            w_state_nxt      = WAIT_LOAD;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (i_mem_rvalid) begin
          w_rd_addr_nxt  = r_ld_rd_addr;
          w_rd_data_nxt  = f_align(r_ld_funct3, r_ld_addr_lo, i_mem_rdata);
          w_rd_write_nxt = r_ld_rd_en && (r_ld_rd_addr != 5'd0);
          w_state_nxt    = IDLE;
        end else begin
          w_state_nxt = WAIT_LOAD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; nothing moves on a disabled edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_rd_addr    <= 5'd0;
      r_rd_data    <= 32'd0;
      r_rd_write   <= 1'b0;
      r_load_fault <= 1'b0;
      r_ld_rd_addr <= 5'd0;
      r_ld_rd_en   <= 1'b0;
      r_ld_funct3  <= 3'd0;
      r_ld_addr_lo <= 2'd0;
    end else if (i_clk_en) begin
      r_state      <= w_state_nxt;
      r_rd_addr    <= w_rd_addr_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_rd_write   <= w_rd_write_nxt;
      r_load_fault <= w_load_fault_nxt;
      r_ld_rd_addr <= w_ld_rd_addr_nxt;
      r_ld_rd_en   <= w_ld_rd_en_nxt;
      r_ld_funct3  <= w_ld_funct3_nxt;
      r_ld_addr_lo <= w_ld_addr_lo_nxt;
    end
  end

  assign o_ready      = (r_state == IDLE);
  assign o_busy       = (r_state == WAIT_LOAD);
  assign o_rd_addr    = r_rd_addr;
  assign o_rd_data    = r_rd_data;
  assign o_rd_write   = r_rd_write;
  assign o_load_fault = r_load_fault;

`ifdef WB_FWD_EN
  // Hit only while the write is actually being presented; x0 never forwards.
  assign o_fwd_rs1_hit = r_rd_write && (r_rd_addr == i_rs1_addr) && (i_rs1_addr != 5'd0);
  assign o_fwd_rs2_hit = r_rd_write && (r_rd_addr == i_rs2_addr) && (i_rs2_addr != 5'd0);
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clk_en = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [4:0]  i_rd_addr = 5'd0;
  logic        i_rd_en = 1'b0;
  logic [31:0] i_result = 32'd0;
  logic        i_is_load = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [1:0]  i_addr_lo = 2'd0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_write;
  logic        o_load_fault;
  logic        o_busy;

  wb_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_en(i_clk_en),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_rd_addr(i_rd_addr), .i_rd_en(i_rd_en), .i_result(i_result),
    .i_is_load(i_is_load), .i_funct3(i_funct3), .i_addr_lo(i_addr_lo),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_write(o_rd_write),
    .o_load_fault(o_load_fault), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        fault;
    logic [4:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  bit  rand_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: load value from the architectural rules.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] x;
    x = w >> (8 * lo);
    case (f3)
      3'd0:    return 32'($signed(x[7:0]));
      3'd1:    return 32'($signed(x[15:0]));
      3'd2:    return w;
      3'd4:    return x & 32'h000000FF;
      3'd5:    return x & 32'h0000FFFF;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_fault(input logic [2:0] f3, input logic [1:0] lo);
    int size;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    size = 1 << f3[1:0];
    return (int'(lo) % size) != 0;
  endfunction

  // Monitor: an event is consumed when the register file would see it.
  always @(negedge i_clk) begin
    if (i_rst_n && i_clk_en && (o_rd_write || o_load_fault)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got write=%0b fault=%0b rd=%0d data=0x%08h, expected none",
                 o_rd_write, o_load_fault, o_rd_addr, o_rd_data);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_is_fault", 32'(o_load_fault), 32'(e.fault));
        check("event_write", 32'(o_rd_write), 32'(!e.fault));
        if (!e.fault) begin
          check("wr_addr", 32'(o_rd_addr), 32'(e.addr));
          check("wr_data", o_rd_data, e.data);
        end
      end
    end
  end

  task automatic tick_raw();
    @(posedge i_clk);
    #1;
  endtask

  task automatic tick();
    tick_raw();
    i_clk_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!o_busy) begin
      // Stray responses while idle must be ignored.
      i_mem_rvalid = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
      i_mem_rdata  = $urandom;
    end
  endtask

  task automatic respond(input logic [4:0] rd, input logic rden, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] word, input int delay,
                         input bit chk_busy);
    bit acc;
    int guard;
    i_mem_rvalid = 1'b0;
    for (int k = 0; k < delay; k++) begin
      if (chk_busy) begin
        check("busy_wait", 32'(o_busy), 32'd1);
        check("ready_wait", 32'(o_ready), 32'd0);
      end
      tick();
      i_mem_rvalid = 1'b0;
    end
    if (rden && rd != 5'd0) exp_q.push_back('{fault: 1'b0, addr: rd, data: ref_load(f3, lo, word)});
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = word;
    guard = 0;
    do begin
      acc = i_clk_en;
      tick();
      guard++;
    end while (!acc && guard < 100);
    if (!acc) begin
      n_checks++;
      $display("FAIL resp_timeout: got no enabled edge, expected one within 100 cycles");
    end
    if (!rand_en) i_mem_rvalid = 1'b0;
  endtask

  task automatic issue(input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                       input logic [4:0] rd, input logic rden, input logic [31:0] res,
                       input logic [31:0] word, input int delay, input bit do_resp);
    bit acc;
    bit flt;
    int guard;
    i_valid = 1'b1; i_is_load = ld; i_funct3 = f3; i_addr_lo = lo;
    i_rd_addr = rd; i_rd_en = rden; i_result = res;
    flt = ld && ref_fault(f3, lo);
    if (!ld && rden && rd != 5'd0) exp_q.push_back('{fault: 1'b0, addr: rd, data: res});
    if (flt) exp_q.push_back('{fault: 1'b1, addr: 5'd0, data: 32'd0});
    guard = 0;
    do begin
      acc = o_ready && i_clk_en;
      tick();
      guard++;
    end while (!acc && guard < 100);
    if (!acc) begin
      n_checks++;
      $display("FAIL accept_timeout: got no accept, expected one within 100 cycles");
    end
    i_valid = 1'b0;
    if (ld && !flt) begin
      i_mem_rvalid = 1'b0;
      if (do_resp) respond(rd, rden, f3, lo, word, delay, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) tick_raw();
    check("rst_write", 32'(o_rd_write), 32'd0);
    check("rst_addr", 32'(o_rd_addr), 32'd0);
    check("rst_data", o_rd_data, 32'd0);
    check("rst_fault", 32'(o_load_fault), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    i_rst_n = 1'b1;
    tick();

    // Non-loads.
    issue(1'b0, 3'd0, 2'd0, 5'd5, 1'b1, 32'hDEADBEEF, 32'd0, 0, 1'b0);
    check("nl_write", 32'(o_rd_write), 32'd1);
    check("nl_addr", 32'(o_rd_addr), 32'd5);
    check("nl_data", o_rd_data, 32'hDEADBEEF);
    issue(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'hDEADBEEF, 32'd0, 0, 1'b0);
    check("nl_x0_write", 32'(o_rd_write), 32'd0);

    // Aligned loads with known answers.
    issue(1'b1, 3'd0, 2'd3, 5'd6, 1'b1, 32'd0, 32'h80112233, 1, 1'b1);
    check("lb_data", o_rd_data, 32'hFFFFFF80);
    issue(1'b1, 3'd4, 2'd3, 5'd6, 1'b1, 32'd0, 32'h80112233, 0, 1'b1);
    check("lbu_data", o_rd_data, 32'h00000080);
    issue(1'b1, 3'd5, 2'd2, 5'd6, 1'b1, 32'd0, 32'h80112233, 2, 1'b1);
    check("lhu_data", o_rd_data, 32'h00008011);

    // LW with a 3-cycle response delay.
    issue(1'b1, 3'd2, 2'd0, 5'd8, 1'b1, 32'd0, 32'h80112233, 0, 1'b0);
    respond(5'd8, 1'b1, 3'd2, 2'd0, 32'h80112233, 3, 1'b1);
    check("lw_data", o_rd_data, 32'h80112233);
    check("lw_write", 32'(o_rd_write), 32'd1);
    check("lw_ready_after", 32'(o_ready), 32'd1);
    check("lw_busy_after", 32'(o_busy), 32'd0);

    // Faulting loads.
    issue(1'b1, 3'd1, 2'd1, 5'd9, 1'b1, 32'd0, 32'd0, 0, 1'b0);
    check("lh_mis_fault", 32'(o_load_fault), 32'd1);
    check("lh_mis_write", 32'(o_rd_write), 32'd0);
    check("lh_mis_ready", 32'(o_ready), 32'd1);
    issue(1'b1, 3'd3, 2'd0, 5'd9, 1'b1, 32'd0, 32'd0, 0, 1'b0);
    check("f3_011_fault", 32'(o_load_fault), 32'd1);
    check("f3_011_ready", 32'(o_ready), 32'd1);
    tick();
    check("fault_pulse_clear", 32'(o_load_fault), 32'd0);

    // Clock enable low holds a pending write for one commit.
    issue(1'b0, 3'd0, 2'd0, 5'd7, 1'b1, 32'h0BADF00D, 32'd0, 0, 1'b0);
    i_clk_en = 1'b0;
    tick_raw();
    check("hold_write_1", 32'(o_rd_write), 32'd1);
    tick_raw();
    check("hold_write_2", 32'(o_rd_write), 32'd1);
    check("hold_data", o_rd_data, 32'h0BADF00D);
    i_clk_en = 1'b1;
    tick_raw();
    check("hold_released", 32'(o_rd_write), 32'd0);

    // Reset while waiting for load data: pending load is dropped.
    issue(1'b1, 3'd2, 2'd0, 5'd9, 1'b1, 32'd0, 32'd0, 0, 1'b0);
    tick();
    check("pre_rst_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(o_ready), 32'd1);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_write", 32'(o_rd_write), 32'd0);
    check("mid_rst_data", o_rd_data, 32'd0);
    tick_raw();
    i_rst_n = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      tick_raw();
      check("post_rst_nowrite", 32'(o_rd_write), 32'd0);
    end
    i_mem_rvalid = 1'b0;

    // Randomized traffic against the reference model.
    rand_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), $urandom,
            $urandom, $urandom_range(0, 3), 1'b1);
    end

    // Drain.
    rand_en = 1'b0;
    i_valid = 1'b0;
    repeat (4) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
